// File: rtl/timer_pkg.sv
// Shared types for the programmable timer.
// State encoding is one-hot so that illegal encodings can be caught cheaply.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    RUN    = 3'b010,
    PAUSED = 3'b100
  } timer_state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_t;

endpackage

// File: rtl/prog_timer_tick_gen.sv
// Tick prescaler: one TICK every PRESCALE enabled cycles.
// Bypassed entirely when PRESCALE is 1.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_in;
      assign unused_in = ^{CLK, RESET, CLR};
      assign TICK = EN;
    end else begin : g_div
      localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt;

      always_ff @(posedge CLK) begin
        if (RESET || CLR) begin
          cnt <= '0;
        end else if (EN) begin
          cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
      end

      assign TICK = EN && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/prog_timer.sv
// Runtime-loadable down-counting timer: one-shot or periodic,
// with pause, abort and a tick prescaler.
module prog_timer
  import timer_pkg::*;
#(
  parameter int W        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         STOP,
  input  logic         PAUSE,
  input  logic         MODE,
  input  logic [W-1:0] LOAD,
  output logic         RDY,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] COUNT
);

  timer_state_t state, state_nx;
  timer_mode_t  mode, mode_nx;
  logic [W-1:0] count, count_nx;
  logic [W-1:0] reload, reload_nx;
  logic         done, done_nx;
  logic         start_acc;
  logic         en;
  logic         tick;

  always_comb begin
    start_acc = (state == IDLE) && START && !STOP && (LOAD != '0);
    en        = (state == RUN) && !STOP && !PAUSE;
  end

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (en),
    .CLR  (start_acc),
    .TICK (tick)
  );

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload;
    mode_nx   = mode;
    done_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_acc) begin
          state_nx  = RUN;
          count_nx  = LOAD;
          reload_nx = LOAD;
          mode_nx   = timer_mode_t'(MODE);
        end
      end
      RUN: begin
        if (STOP) begin
          state_nx = IDLE;
          count_nx = '0;
        end else if (PAUSE) begin
          state_nx = PAUSED;
        end else if (tick) begin
          if (count == W'(1)) begin
            done_nx = 1'b1;
            if (mode == ONE_SHOT) begin
              state_nx = IDLE;
              count_nx = '0;
            end else begin
              count_nx = reload;
            end
          end else begin
            count_nx = count - W'(1);
          end
        end
      end
      PAUSED: begin
        if (STOP) begin
          state_nx = IDLE;
          count_nx = '0;
        end else if (!PAUSE) begin
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

  always_comb begin
    RDY   = (state == IDLE);
    BUSY  = (state == RUN) || (state == PAUSED);
    DONE  = done;
    COUNT = count;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= ONE_SHOT;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      reload <= reload_nx;
      mode   <= mode_nx;
      done   <= done_nx;
    end
  end

endmodule
